imem_responder: RTL and testbench

Multi-cycle instruction-memory responder that services the fetch stage's PC-addressed read requests. It accepts a request, holds the fetch stage in stall for a fixed programmable latency, then returns the 16-bit instruction with a one-cycle `done` pulse. It sits between fetch and the instruction storage, replacing the ideal single-cycle instruction memory. It also provides a preload write port and a flush input so fetch can cancel an in-flight fetch on redirect.

---
 rtl/imem_pkg.sv | 14 +
 rtl/imem_array.sv | 23 ++
 rtl/imem_responder.sv | 118 +++++++++++
 tb/tb_imem_responder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the multi-cycle instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [15:0] NOP_INSTR   = 16'h0800;
  localparam int          MAX_LATENCY = 7;
  localparam int          CNT_W       = 3;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, asynchronous read, contents not reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [15:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [15:0]           rdata
);

  logic [15:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory responder: fixed programmable latency, stall
// while in flight, one-cycle done strobe, flush cancel and idle-only preload.
//
// state | meaning
// IDLE  | no request in flight; preload writes accepted
// BUSY  | latency counter running, stall asserted
// RESP  | done cycle; a new request may be accepted back-to-back
module imem_responder
  import imem_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic [15:0] addr,
  input  logic        flush,
  input  logic        wr,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        err
);

  // A request taken in RESP overlaps its first latency cycle with that done
  // cycle, so it needs one fewer BUSY cycle to keep one fetch per LATENCY.
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_NEXT  = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [DEPTH_LOG2:0]   addr_q, addr_n;
  logic                  wr_en;
  logic [15:0]           rdata;
  logic [15:0]           word;
  logic                  unused_bits;

  assign wr_en       = (state == IDLE) && wr;
  assign unused_bits = ^{addr[15:DEPTH_LOG2+1], wr_addr[15:DEPTH_LOG2+1], wr_addr[0]};

  imem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr[DEPTH_LOG2:1]),
    .wdata (wr_data),
    .raddr (addr_n[DEPTH_LOG2:1]),
    .rdata (rdata)
  );

  // With LATENCY=1 the read happens on the same edge as a coincident preload.
  assign word = (wr_en && (wr_addr[DEPTH_LOG2:1] == addr_n[DEPTH_LOG2:1])) ? wr_data : rdata;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    case (state)
      IDLE: begin
        if (rd && !flush) begin
          addr_n = addr[DEPTH_LOG2:0];
          if (LATENCY == 1) begin
            state_n = RESP;
          end else begin
            state_n = BUSY;
            cnt_n   = CNT_FIRST;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          state_n = RESP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rd && !flush) begin
          addr_n = addr[DEPTH_LOG2:0];
          if (LATENCY == 1) begin
            state_n = RESP;
          end else begin
            state_n = BUSY;
            cnt_n   = CNT_NEXT;
          end
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      done     <= 1'b0;
      stall    <= 1'b0;
      err      <= 1'b0;
      data_out <= NOP_INSTR;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      addr_q   <= addr_n;
      done     <= (state_n == RESP);
      stall    <= (state_n == BUSY);
      err      <= (state_n == RESP) && addr_n[0];
      data_out <= ((state_n == RESP) && !addr_n[0]) ? word : NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: LATENCY=4 and LATENCY=1 instances share stimulus and
// are checked every cycle against a stall-count model, plus directed literal checks.
module tb_imem_responder;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd = 1'b0, flush = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0, wr_addr = '0, wr_data = '0;

  logic [1:0]       done_v, stall_v, err_v;
  logic [1:0][15:0] data_v;

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(4), .DEPTH_LOG2(10)) dut0 (
    .clk(clk), .rst(rst), .rd(rd), .addr(addr), .flush(flush), .wr(wr),
    .wr_addr(wr_addr), .wr_data(wr_data), .data_out(data_v[0]),
    .done(done_v[0]), .stall(stall_v[0]), .err(err_v[0])
  );

  imem_responder #(.LATENCY(1), .DEPTH_LOG2(10)) dut1 (
    .clk(clk), .rst(rst), .rd(rd), .addr(addr), .flush(flush), .wr(wr),
    .wr_addr(wr_addr), .wr_data(wr_data), .data_out(data_v[1]),
    .done(done_v[1]), .stall(stall_v[1]), .err(err_v[1])
  );

  // Model: per instance, the number of stall cycles still owed before the done cycle.
  int          lat [2] = '{4, 1};
  logic [15:0] mmem [2][1024];
  bit          e_done [2], e_stall [2], e_err [2];
  logic [15:0] e_data [2];
  int          left [2];
  logic [15:0] req [2];

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      e_done[i] = 0; e_stall[i] = 0; e_err[i] = 0; e_data[i] = NOP; left[i] = 0;
    end
  endfunction

  function automatic void fire(int i);
    e_done[i] = 1;
    if (req[i][0]) e_err[i] = 1;
    else e_data[i] = mmem[i][req[i][10:1]];
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 2; i++) begin
      bit was_done, was_stall;
      was_done  = e_done[i];
      was_stall = e_stall[i];
      if (!was_done && !was_stall && wr) mmem[i][wr_addr[10:1]] = wr_data;
      e_done[i] = 0; e_stall[i] = 0; e_err[i] = 0; e_data[i] = NOP;
      if (was_stall) begin
        if (!flush) begin
          left[i]--;
          if (left[i] == 0) fire(i);
          else e_stall[i] = 1;
        end
      end else if (rd && !flush) begin
        req[i]  = addr;
        left[i] = was_done ? lat[i] - 1 : ((lat[i] == 1) ? 0 : lat[i]);
        if (left[i] == 0) fire(i);
        else e_stall[i] = 1;
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("done[%0d]", i), done_v[i], e_done[i]);
        chk($sformatf("stall[%0d]", i), stall_v[i], e_stall[i]);
        chk($sformatf("err[%0d]", i), err_v[i], e_err[i]);
        chk($sformatf("data[%0d]", i), data_v[i], e_data[i]);
      end
    end
  end

  task automatic wait_done0(output int n);
    n = 0;
    while (!done_v[0] && n < 20) begin
      n++;
      cycle();
    end
  endtask

  task automatic req0(input logic [15:0] a, input int exp_n, input logic [15:0] exp_d,
                      input logic exp_e, input string nm);
    int n;
    rd = 1; addr = a;
    cycle();
    rd = 0;
    wait_done0(n);
    chk({nm, " done"}, done_v[0], 16'd1);
    chk({nm, " stall cycles"}, 16'(n), 16'(exp_n));
    chk({nm, " data"}, data_v[0], exp_d);
    chk({nm, " err"}, err_v[0], exp_e);
    cycle();
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    wr = 1; wr_addr = a; wr_data = d;
    cycle();
    wr = 0;
  endtask

  initial begin
    int n;
    model_reset();
    #2 rst = 1;
    #1;
    chk("reset data", data_v[0], NOP);
    chk("reset done", done_v[0], 16'd0);
    chk("reset stall", stall_v[0], 16'd0);
    chk("reset err", err_v[0], 16'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    chk_en = 1;

    for (int i = 0; i < 1024; i++) begin
      preload({5'($urandom), 10'(i), 1'($urandom)}, 16'($urandom));
    end
    preload(16'h0000, 16'h1234);
    preload(16'h0002, 16'hA5A5);
    preload(16'h0004, 16'h5A5A);
    preload(16'h0010, 16'hBEEF);

    // reset on the second BUSY cycle
    rd = 1; addr = 16'h0000;
    cycle();
    rd = 0;
    cycle();
    rst = 1;
    #1;
    chk("midreset data", data_v[0], NOP);
    chk("midreset done", done_v[0], 16'd0);
    chk("midreset stall", stall_v[0], 16'd0);
    chk("midreset err", err_v[0], 16'd0);
    model_reset();
    cycle();
    cycle();
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("no done after reset", done_v[0], 16'd0);
    end
    req0(16'h0000, 4, 16'h1234, 1'b0, "reissue");

    // back-to-back
    rd = 1; addr = 16'h0002;
    cycle();
    wait_done0(n);
    chk("b2b first stalls", 16'(n), 16'd4);
    chk("b2b first data", data_v[0], 16'hA5A5);
    addr = 16'h0004;
    cycle();
    wait_done0(n);
    chk("b2b second stalls", 16'(n), 16'd3);
    chk("b2b second data", data_v[0], 16'h5A5A);
    rd = 0;
    cycle();

    req0(16'h0003, 4, NOP, 1'b1, "unaligned");

    // flush in BUSY
    rd = 1; addr = 16'h0010;
    cycle();
    rd = 0;
    cycle();
    flush = 1;
    cycle();
    flush = 0;
    chk("flush busy stall", stall_v[0], 16'd0);
    for (int k = 0; k < 6; k++) begin
      chk("flush busy no done", done_v[0], 16'd0);
      cycle();
    end

    // flush together with rd in RESP
    rd = 1; addr = 16'h0010;
    cycle();
    rd = 0;
    wait_done0(n);
    chk("flush resp done", done_v[0], 16'd1);
    chk("flush resp data", data_v[0], 16'hBEEF);
    flush = 1; rd = 1; addr = 16'h0002;
    cycle();
    flush = 0; rd = 0;
    for (int k = 0; k < 6; k++) begin
      chk("flush resp stall", stall_v[0], 16'd0);
      chk("flush resp no done", done_v[0], 16'd0);
      cycle();
    end

    req0(16'h0810, 4, 16'hBEEF, 1'b0, "wrap");

    // preload dropped while busy
    rd = 1; addr = 16'h0010;
    cycle();
    rd = 0;
    wr = 1; wr_addr = 16'h0010; wr_data = 16'hFFFF;
    cycle();
    wr = 0;
    wait_done0(n);
    chk("busy wr data", data_v[0], 16'hBEEF);
    cycle();
    req0(16'h0010, 4, 16'hBEEF, 1'b0, "busy wr reread");

    // coincident write and read in IDLE
    wr = 1; wr_addr = 16'h0020; wr_data = 16'hC0DE; rd = 1; addr = 16'h0020;
    cycle();
    wr = 0; rd = 0;
    chk("coincide lat1 done", done_v[1], 16'd1);
    chk("coincide lat1 data", data_v[1], 16'hC0DE);
    wait_done0(n);
    chk("coincide lat4 data", data_v[0], 16'hC0DE);
    cycle();

    // LATENCY=1 with rd held high
    rd = 1; addr = 16'h0002;
    cycle();
    for (int k = 0; k < 8; k++) begin
      chk("lat1 done", done_v[1], 16'd1);
      chk("lat1 stall", stall_v[1], 16'd0);
      addr = 16'($urandom) & 16'hFFFE;
      cycle();
    end
    rd = 0;
    repeat (6) cycle();

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      rd      = ($urandom % 2) == 0;
      flush   = ($urandom % 10) == 0;
      wr      = ($urandom % 5) == 0;
      addr    = 16'($urandom) & ((($urandom % 4) == 0) ? 16'hFFFF : 16'hFFFE);
      wr_addr = 16'($urandom);
      wr_data = 16'($urandom);
      if (($urandom % 700) == 0) begin
        rst = 1;
        model_reset();
        cycle();
        rst = 0;
      end else begin
        cycle();
      end
    end
    rd = 0; flush = 0; wr = 0;
    repeat (6) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
